mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported unified instruction/data memory between NREQ requesters
//  (fetch, load/store, debug/DMA). Replaces the fixed two-phase IF/MEM time split.
//  Arbitrates one access per cycle with valid/ready handshakes and returns responses
//  after a fixed memory latency, tagged to the issuing requester.
//  Sits between the pipeline stages and the mem block.
// PARAMETERS
//  NREQ      2   number of requesters (2..8); index 0 = instruction fetch
//  AW        32  address width
//  DW        32  data width
//  RD_LAT    1   mem read latency in cycles (1..4)
//  PRIO_MODE 0   0 = round-robin; 1 = fixed priority (lowest index wins)
// PORTS
//  clk        in   1        clock
//  rst        in   1        reset: asynchronous, active-high
//  req_valid  in   NREQ     requester i presents an access
//  req_ready  out  NREQ     one-hot grant; access accepted when valid&ready
//  req_we     in   NREQ     1 = store, 0 = load
//  req_addr   in   NREQ*AW  byte address, requester i in [i*AW +: AW]
//  req_wdata  in   NREQ*DW  store data, packed as req_addr
//  req_funct3 in   NREQ*3   RV32 size/sign code (LB/LH/LW/LBU/LHU, SB/SH/SW)
//  rsp_valid  out  NREQ     one-hot response strobe, one cycle
//  rsp_rdata  out  DW       load data, valid with rsp_valid (0 for stores)
//  rsp_err    out  1        misaligned access flag, valid with rsp_valid
//  mem_en     out  1        memory access enable
//  mem_we     out  1        memory write enable
//  mem_addr   out  AW       memory address
//  mem_wdata  out  DW       memory write data
//  mem_funct3 out  3        memory size code
//  mem_rdata  in   DW       memory read data, RD_LAT cycles after mem_en
// BEHAVIOUR
//  - Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_en=0,
//    mem_we=0. RR pointer=0. Response pipeline cleared.
//  - Grant is combinational from req_valid and the pointer. At most one ready bit per cycle.
//    The ready bit is only asserted when its requester's valid is high.
//  - Round-robin: the winner is the first valid index at or after the pointer, wrapping.
//    After a grant, the pointer becomes winner+1 mod NREQ and is otherwise held.
//    Worst-case wait is NREQ-1 grants.
//  - Fixed mode: the lowest valid index wins. The pointer is unused.
//  - The mem_* outputs carry the winner's fields in the same cycle. mem_en=0 when no
//    request is valid.
//  - Requesters hold all fields stable while valid && !ready. Dropping valid before the
//    grant is legal.
//  - Misalignment: a word access with addr[1:0]!=0, or a half access with addr[0]!=0,
//    is still granted but gets mem_en=0. Its response carries rsp_err=1 and rsp_rdata=0.
//  - Response pipeline: a shift register RD_LAT deep holding {valid, id, err, we}.
//    The rsp for a grant in cycle t appears in cycle t+RD_LAT.
//    rsp_rdata = mem_rdata only for aligned loads.
//  - Stores also produce a rsp_valid, as a write-ack. This lets fetch/MEM stalls key off
//    a single signal.
//  - Back-to-back grants every cycle are fully pipelined: sustained throughput is 1 per cycle.
//  - The same requester may have up to RD_LAT accesses in flight. Responses return in
//    grant order.
//  - rst mid-operation: in-flight responses are discarded and never delivered. The
//    pointer returns to 0.
// STRUCTURE
//  - Shared package: funct3 size codes (reuse the defines.v constants) and
//    the misalign-check function.
//  - Sub-module rr_arbiter (NREQ, PRIO_MODE): req vector -> one-hot grant and
//    pointer update.
//  - Top: field mux, response shift register, and alignment check.
// TESTING
//  1 NREQ=2, both valid every cycle for 6 cycles (RR):
//    -> grants alternate 0,1,0,1,0,1; each rsp at t+RD_LAT.
//  2 PRIO_MODE=1, both valid:
//    -> req 0 is granted every cycle; req 1 is never ready until req 0 drops valid.
//  3 LW at 0x10, memory word 0xDEADBEEF, RD_LAT=2:
//    -> rsp_valid[id]=1 and rsp_rdata=0xDEADBEEF exactly 2 cycles after the grant.
//  4 SW at 0x12 (misaligned):
//    -> granted, mem_en=0, rsp_err=1 one RD_LAT later; memory unchanged.
//  5 SW 0x55 to 0x20 granted, then LW 0x20 on the next cycle:
//    -> the load returns 0x55 and the responses come back in order.
//  6 rst asserted while 2 reads are in flight:
//    -> no rsp_valid after rst; req_ready=0 and the pointer is 0 after release.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified memory port arbiter: RV32 size codes,
// the response tag carried down the latency pipeline, and the alignment check.
package mem_port_arbiter_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // Requester ids are 3 bits wide so up to 8 requesters can be tagged.
    localparam int IDW = 3;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10
    } size_e;

    typedef struct packed {
        logic           valid;
        logic [IDW-1:0] id;
        logic           err;
        logic           we;
    } rsp_tag_t;

    // funct3[1:0] encodes the access size for both loads and stores.
    function automatic logic isMisaligned(input logic [2:0] funct3, input logic [1:0] addrLsb);
        logic mis;
        mis = 1'b0;
        case (funct3[1:0])
            SZ_WORD: mis = (addrLsb != 2'b00);
            SZ_HALF: mis = addrLsb[0];
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter.sv
// Request vector to one-hot grant, either round-robin from a rotating pointer
// or fixed lowest-index priority.
module rr_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int PRIO_MODE = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] i_req,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_grantId,
    output logic            o_anyGrant
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]   r_ptr;
    logic [PW-1:0]   w_nextPtr;
    logic [NREQ-1:0] w_mask;
    logic [NREQ-1:0] w_masked;
    logic [NREQ-1:0] w_cand;

    // Requests at or above the pointer get first pick; if none, fall back to
    // the full vector, which gives the wrap-around search order.
    always_comb begin
        w_mask = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (PRIO_MODE == 0 && i >= int'(r_ptr)) begin
                w_mask[i] = 1'b1;
            end
        end
        w_masked   = i_req & w_mask;
        w_cand     = (w_masked != '0) ? w_masked : i_req;
        o_grant    = '0;
        o_grantId  = '0;
        o_anyGrant = 1'b0;
        w_nextPtr  = r_ptr;
        if (!rst) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!o_anyGrant && w_cand[i]) begin
                    o_anyGrant = 1'b1;
                    o_grant[i] = 1'b1;
                    o_grantId  = IDW'(i);
                    w_nextPtr  = (i == NREQ - 1) ? '0 : PW'(i + 1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (o_anyGrant && PRIO_MODE == 0) begin
            r_ptr <= w_nextPtr;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between NREQ requesters: one grant per cycle,
// responses returned RD_LAT cycles later tagged with the issuing requester.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int RD_LAT    = 1,
    parameter int PRIO_MODE = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req_valid,
    output logic [NREQ-1:0]    req_ready,
    input  logic [NREQ-1:0]    req_we,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    input  logic [NREQ*3-1:0]  req_funct3,
    output logic [NREQ-1:0]    rsp_valid,
    output logic [DW-1:0]      rsp_rdata,
    output logic               rsp_err,
    output logic               mem_en,
    output logic               mem_we,
    output logic [AW-1:0]      mem_addr,
    output logic [DW-1:0]      mem_wdata,
    output logic [2:0]         mem_funct3,
    input  logic [DW-1:0]      mem_rdata
);

    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_winId;
    logic            w_any;
    logic            w_we;
    logic [AW-1:0]   w_addr;
    logic [DW-1:0]   w_wdata;
    logic [2:0]      w_funct3;
    logic            w_misalign;
    rsp_tag_t        r_pipe [RD_LAT];
    rsp_tag_t        w_head;

    rr_arbiter #(
        .NREQ      (NREQ),
        .PRIO_MODE (PRIO_MODE)
    ) u_arb (
        .clk        (clk),
        .rst        (rst),
        .i_req      (req_valid),
        .o_grant    (w_grant),
        .o_grantId  (w_winId),
        .o_anyGrant (w_any)
    );

    assign req_ready = w_grant;

    // Route the winning requester's fields to the memory port.
    always_comb begin
        w_we     = 1'b0;
        w_addr   = '0;
        w_wdata  = '0;
        w_funct3 = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_we     = req_we[i];
                w_addr   = req_addr[i*AW +: AW];
                w_wdata  = req_wdata[i*DW +: DW];
                w_funct3 = req_funct3[i*3 +: 3];
            end
        end
    end

    // A misaligned access is still granted (so the requester sees its handshake
    // complete) but never reaches the memory.
    assign w_misalign = w_any & isMisaligned(w_funct3, w_addr[1:0]);
    assign mem_en     = w_any & ~w_misalign;
    assign mem_we     = mem_en & w_we;
    assign mem_addr   = w_addr;
    assign mem_wdata  = w_wdata;
    assign mem_funct3 = w_funct3;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pipe[0] <= '{valid: w_any, id: w_winId, err: w_misalign, we: w_we};
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign w_head = r_pipe[RD_LAT-1];

    // Memory data lines up with the tag leaving the last stage; only aligned
    // loads forward it, stores and faulted accesses return zero.
    always_comb begin
        rsp_valid = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_head.valid && w_head.id == IDW'(i)) begin
                rsp_valid[i] = 1'b1;
            end
        end
        rsp_err   = w_head.valid & w_head.err;
        rsp_rdata = (w_head.valid && !w_head.err && !w_head.we) ? mem_rdata : '0;
    end

endmodule
